// File: rtl/fifo_pkg.sv
// Shared types and elaboration helpers for the FIFO family.
package fifo_pkg;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage with one synchronous write port and one registered read port.
module fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_d, rdata_q;

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (!clr_n) begin
            rdata_d = '0;
        end else if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/param_fifo.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags and sticky error flags.
module param_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 16,
    parameter int AFULL_LVL  = DEPTH - 2,
    parameter int AEMPTY_LVL = 2
) (
    input  logic                     clk,
    input  logic                     FIFO_reset_n,
    input  logic                     FIFO_clr_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     pop,
    output logic [DATA_W-1:0]        data_out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int            AW       = addr_w(DEPTH);
    localparam int            CW       = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LVL);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LVL);
    localparam logic          AF_RST   = (AFULL_LVL == 0);

    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
        $error("param_fifo: DEPTH must be a power of 2 and >= 2");
    end
    if (!(AEMPTY_LVL < AFULL_LVL && AFULL_LVL <= DEPTH)) begin : g_bad_levels
        $error("param_fifo: need AEMPTY_LVL < AFULL_LVL <= DEPTH");
    end

    logic [AW-1:0] wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
    logic [CW-1:0] count_d, count_q;
    fifo_err_t     err_d, err_q;
    logic          full_d, full_q, empty_d, empty_q;
    logic          afull_d, afull_q, aempty_d, aempty_q;
    logic          push_ok, pop_ok;

    // When full, a simultaneous pop frees the slot the push lands in.
    assign push_ok = push & (~full_q | pop);
    assign pop_ok  = pop & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q;
        if (!FIFO_clr_n) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            err_d    = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (push && !push_ok) err_d.overflow  = 1'b1;
            if (pop && !pop_ok)   err_d.underflow = 1'b1;
        end
        // Flags are registered alongside count so they never glitch.
        full_d   = (count_d == DEPTH_C);
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= AFULL_C);
        aempty_d = (count_d <= AEMPTY_C);
    end

    always_ff @(posedge clk or negedge FIFO_reset_n) begin
        if (!FIFO_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= AF_RST;
            aempty_q <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .rst_n (FIFO_reset_n),
        .clr_n (FIFO_clr_n),
        .we    (push_ok & FIFO_clr_n),
        .waddr (wr_ptr_q),
        .wdata (data_in),
        .re    (pop_ok & FIFO_clr_n),
        .raddr (rd_ptr_q),
        .rdata (data_out)
    );

    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign overflow     = err_q.overflow;
    assign underflow    = err_q.underflow;

endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo at DATA_W=8, DEPTH=4, AFULL_LVL=3, AEMPTY_LVL=1.
module tb_param_fifo;

    logic       clk = 1'b0;
    logic       FIFO_reset_n, FIFO_clr_n, push, pop;
    logic [7:0] data_in, data_out;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [2:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    param_fifo #(
        .DATA_W     (8),
        .DEPTH      (4),
        .AFULL_LVL  (3),
        .AEMPTY_LVL (1)
    ) dut (
        .clk          (clk),
        .FIFO_reset_n (FIFO_reset_n),
        .FIFO_clr_n   (FIFO_clr_n),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Occupancy plus the four flags implied by it for DEPTH=4, AF=3, AE=1.
    task automatic chk_cnt(input string tag, input int c);
        chk({tag, " count"}, 32'(count), 32'(c));
        chk({tag, " full"}, 32'(full), 32'(c == 4));
        chk({tag, " empty"}, 32'(empty), 32'(c == 0));
        chk({tag, " afull"}, 32'(almost_full), 32'(c >= 3));
        chk({tag, " aempty"}, 32'(almost_empty), 32'(c <= 1));
    endtask

    task automatic chk_err(input string tag, input logic ovf, input logic udf);
        chk({tag, " overflow"}, 32'(overflow), 32'(ovf));
        chk({tag, " underflow"}, 32'(underflow), 32'(udf));
    endtask

    task automatic do_push(input logic [7:0] d);
        push = 1'b1; data_in = d;
        step();
        push = 1'b0;
    endtask

    task automatic do_pop();
        pop = 1'b1;
        step();
        pop = 1'b0;
    endtask

    initial begin
        FIFO_reset_n = 1'b0; FIFO_clr_n = 1'b1;
        push = 1'b0; pop = 1'b0; data_in = 8'h00;
        repeat (5) step();
        chk_cnt("reset", 0);
        chk("reset data_out", 32'(data_out), 32'h00);
        chk_err("reset", 1'b0, 1'b0);
        FIFO_reset_n = 1'b1;
        step();

        // 1: fill then drain
        for (int i = 1; i <= 4; i++) begin
            do_push(8'(i));
            chk_cnt("t1 push", i);
        end
        for (int i = 1; i <= 4; i++) begin
            do_pop();
            chk("t1 pop data", 32'(data_out), 32'(i));
            chk_cnt("t1 pop", 4 - i);
        end

        // 2: overflow on full
        for (int i = 1; i <= 4; i++) do_push(8'(i));
        do_push(8'h05);
        chk_cnt("t2 ovf", 4);
        chk_err("t2 ovf", 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            do_pop();
            chk("t2 pop data", 32'(data_out), 32'(i));
        end
        step();
        chk_cnt("t2 drained", 0);
        chk("t2 hold", 32'(data_out), 32'h04);

        // 3: underflow and push+pop on empty
        do_pop();
        chk_err("t3 udf", 1'b1, 1'b1);
        chk("t3 hold", 32'(data_out), 32'h04);
        chk_cnt("t3 udf", 0);
        push = 1'b1; pop = 1'b1; data_in = 8'h33;
        step();
        push = 1'b0; pop = 1'b0;
        chk_cnt("t3 pp empty", 1);
        chk("t3 no bypass", 32'(data_out), 32'h04);
        do_pop();
        chk("t3 pop data", 32'(data_out), 32'h33);
        chk_cnt("t3 pop", 0);

        // 4: pointer wrap with alternating push/pop
        for (int i = 0; i < 10; i++) begin
            do_push(8'hA0 + 8'(i));
            chk_cnt("t4 push", 1);
            do_pop();
            chk("t4 data", 32'(data_out), 32'hA0 + 32'(i));
            chk_cnt("t4 pop", 0);
        end

        // clear the sticky errors before the full push+pop case
        FIFO_clr_n = 1'b0;
        step();
        FIFO_clr_n = 1'b1;
        chk_cnt("clr", 0);
        chk_err("clr", 1'b0, 1'b0);

        // 5: push+pop while full
        for (int i = 0; i < 4; i++) do_push(8'hB0 + 8'(i));
        chk_cnt("t5 full", 4);
        push = 1'b1; pop = 1'b1; data_in = 8'hAA;
        step();
        push = 1'b0; pop = 1'b0;
        chk("t5 data", 32'(data_out), 32'hB0);
        chk_cnt("t5 pp full", 4);
        chk_err("t5 pp full", 1'b0, 1'b0);
        do_pop(); chk("t5 d1", 32'(data_out), 32'hB1);
        do_pop(); chk("t5 d2", 32'(data_out), 32'hB2);
        do_pop(); chk("t5 d3", 32'(data_out), 32'hB3);
        do_pop(); chk("t5 d4", 32'(data_out), 32'hAA);
        chk_cnt("t5 drained", 0);

        // 6: clear with push pending, then async reset mid-burst
        do_push(8'hC0);
        do_push(8'hC1);
        do_pop();
        chk("t6 pre-clr data", 32'(data_out), 32'hC0);
        do_push(8'hC2);
        chk_cnt("t6 pre-clr", 2);
        do_pop();
        chk("t6 udf setup data", 32'(data_out), 32'hC1);
        do_pop();
        do_pop();
        chk_err("t6 pre-clr err", 1'b0, 1'b1);
        do_push(8'hC3);
        do_push(8'hC4);
        FIFO_clr_n = 1'b0; push = 1'b1; data_in = 8'hC5;
        step();
        FIFO_clr_n = 1'b1; push = 1'b0;
        chk_cnt("t6 clr", 0);
        chk_err("t6 clr", 1'b0, 1'b0);
        chk("t6 clr data", 32'(data_out), 32'h00);
        do_push(8'hD0);
        do_pop();
        chk("t6 after clr", 32'(data_out), 32'hD0);

        do_push(8'hE0);
        push = 1'b1; data_in = 8'hE1;
        step();
        #2 FIFO_reset_n = 1'b0;
        #1;
        chk_cnt("t6 async rst", 0);
        chk("t6 async data", 32'(data_out), 32'h00);
        chk_err("t6 async rst", 1'b0, 1'b0);
        push = 1'b0;
        #1 FIFO_reset_n = 1'b1;
        step();
        chk_cnt("t6 post rst", 0);
        do_push(8'hF0);
        do_pop();
        chk("t6 post rst data", 32'(data_out), 32'hF0);
        chk_cnt("t6 final", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
